// File: rtl/msg_padder_pkg.sv
// Shared SHA-2 definitions: algorithm codes, block/length-field sizes and
// the padder FSM encoding.
package msg_padder_pkg;

  typedef enum logic [1:0] {
    SHA224 = 2'b00,
    SHA256 = 2'b01,
    SHA384 = 2'b10,
    SHA512 = 2'b11
  } sha_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_PAD  = 2'd3
  } pad_state_e;

  // Sizes in bytes; 9 bits so that two whole 1024-bit blocks (256) fit.
  localparam logic [8:0] BLOCK_BYTES_512  = 9'd64;
  localparam logic [8:0] BLOCK_BYTES_1024 = 9'd128;
  localparam logic [8:0] LEN_BYTES_512    = 9'd8;
  localparam logic [8:0] LEN_BYTES_1024   = 9'd16;

  // Block size L: the type msb selects 1024-bit blocks.
  function automatic logic [8:0] block_bytes(input sha_type_e t);
    return t[1] ? BLOCK_BYTES_1024 : BLOCK_BYTES_512;
  endfunction

  // Length field size F at the end of the final block.
  function automatic logic [8:0] len_field_bytes(input sha_type_e t);
    return t[1] ? LEN_BYTES_1024 : LEN_BYTES_512;
  endfunction

endpackage

// File: rtl/msg_padder.sv
// SHA-2 message padder: packs a byte stream into 512-bit beats, appends the
// 0x80 terminator, zero fill and the big-endian bit length.
module msg_padder
  import msg_padder_pkg::*;
#(
  parameter int S_AXIS_DATA_WIDTH = 64,
  parameter int M_AXIS_DATA_WIDTH = 512
) (
  input  logic                           axi_aclk,
  input  logic                           axi_reset,
  input  logic [1:0]                     sha_type,
  input  logic                           en,
  input  logic [S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
);

  localparam int S_LANES = S_AXIS_DATA_WIDTH / 8;
  localparam int M_BYTES = M_AXIS_DATA_WIDTH / 8;
  localparam int PTR_W   = $clog2(M_BYTES);
  localparam int KEEP_W  = $clog2(S_LANES + 1);

  pad_state_e                   state_q, state_d;
  sha_type_e                    type_q;
  logic [63:0]                  cnt_q;
  logic [M_AXIS_DATA_WIDTH-1:0] buf_q;
  logic                         last_seen_q;   // tlast taken on a filling beat; pad after emit
  logic                         pad_mode_q;    // beats now being emitted are padding beats
  logic [1:0]                   beats_left_q;  // padding beats still to follow the current one
  logic                         tlast_q;

  logic [PTR_W-1:0]             ptr;
  logic [PTR_W-1:0]             lane_idx [S_LANES];
  logic [KEEP_W-1:0]            keep_cnt;
  logic [PTR_W:0]               ptr_sum;
  logic                         wrap;
  logic                         s_hs, m_hs;
  logic [M_AXIS_DATA_WIDTH-1:0] load_beat;
  logic [M_AXIS_DATA_WIDTH-1:0] pad_beat;
  logic [63:0]                  bit_len;
  logic [8:0]                   blk_l, fld_f, q9, base9, need9, span9;
  logic [1:0]                   n_pad;

  // Write the 64-bit bit length big-endian into the top 8 bytes of a beat.
  function automatic logic [M_AXIS_DATA_WIDTH-1:0] put_length(
    input logic [M_AXIS_DATA_WIDTH-1:0] b,
    input logic [63:0]                  bits
  );
    logic [M_AXIS_DATA_WIDTH-1:0] r;
    r = b;
    for (int k = 0; k < 8; k++) r[8*(M_BYTES-1-k) +: 8] = bits[8*k +: 8];
    return r;
  endfunction

  // Place the 0x80 terminator at byte 'at' and clear every byte above it.
  function automatic logic [M_AXIS_DATA_WIDTH-1:0] mark_end(
    input logic [M_AXIS_DATA_WIDTH-1:0] b,
    input logic [PTR_W-1:0]             at
  );
    logic [M_AXIS_DATA_WIDTH-1:0] r;
    r = b;
    for (int j = 0; j < M_BYTES; j++) begin
      if (PTR_W'(j) == at)     r[8*j +: 8] = 8'h80;
      else if (PTR_W'(j) > at) r[8*j +: 8] = 8'h00;
    end
    return r;
  endfunction

  assign ptr      = cnt_q[PTR_W-1:0];
  assign keep_cnt = KEEP_W'($countones(s_axis_tkeep));
  assign ptr_sum  = (PTR_W+1)'(ptr) + (PTR_W+1)'(keep_cnt);
  assign wrap     = (ptr_sum == (PTR_W+1)'(M_BYTES));
  assign s_hs     = s_axis_tvalid && s_axis_tready;
  assign m_hs     = m_axis_tvalid && m_axis_tready;
  assign bit_len  = {cnt_q[60:0], 3'b000};

  // Merge the kept input lanes into the beat buffer at the current pointer.
  always_comb begin
    load_beat = buf_q;
    for (int i = 0; i < S_LANES; i++) begin
      lane_idx[i] = ptr + PTR_W'(i);
      if (s_axis_tkeep[i]) load_beat[8*lane_idx[i] +: 8] = s_axis_tdata[8*i +: 8];
    end
  end

  // Padding plan: terminator beat contents and how many beats remain to the end.
  always_comb begin
    blk_l    = block_bytes(type_q);
    fld_f    = len_field_bytes(type_q);
    q9       = type_q[1] ? {2'b00, cnt_q[6:0]} : {3'b000, cnt_q[5:0]};
    base9    = q9 - 9'(ptr);
    need9    = ((q9 + 9'd1 + fld_f) <= blk_l) ? blk_l : {blk_l[7:0], 1'b0};
    span9    = need9 - base9;
    n_pad    = 2'(span9 >> 6);
    pad_beat = mark_end(buf_q, ptr);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = buf_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: begin
        s_axis_tready = 1'b1;
        if (s_hs) begin
          if (wrap)              state_d = ST_EMIT;
          else if (s_axis_tlast) state_d = ST_PAD;
        end
      end
      ST_EMIT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = tlast_q;
        if (m_hs) begin
          if (pad_mode_q)       state_d = (beats_left_q != 2'd0) ? ST_EMIT : ST_IDLE;
          else if (last_seen_q) state_d = ST_PAD;
          else                  state_d = ST_LOAD;
        end
      end
      ST_PAD:  state_d = ST_EMIT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Buffer, byte counter and padding bookkeeping.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      type_q       <= SHA224;
      cnt_q        <= '0;
      buf_q        <= '0;
      last_seen_q  <= 1'b0;
      pad_mode_q   <= 1'b0;
      beats_left_q <= '0;
      tlast_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            type_q       <= sha_type_e'(sha_type);
            cnt_q        <= '0;
            buf_q        <= '0;
            last_seen_q  <= 1'b0;
            pad_mode_q   <= 1'b0;
            beats_left_q <= '0;
            tlast_q      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (s_hs) begin
            buf_q <= load_beat;
            cnt_q <= cnt_q + 64'(keep_cnt);
            if (s_axis_tlast) last_seen_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (m_hs && pad_mode_q) begin
            if (beats_left_q != 2'd0) begin
              buf_q        <= (beats_left_q == 2'd1) ? put_length('0, bit_len) : '0;
              tlast_q      <= (beats_left_q == 2'd1);
              beats_left_q <= beats_left_q - 2'd1;
            end else begin
              pad_mode_q <= 1'b0;
              tlast_q    <= 1'b0;
            end
          end
        end
        ST_PAD: begin
          buf_q        <= (n_pad == 2'd1) ? put_length(pad_beat, bit_len) : pad_beat;
          tlast_q      <= (n_pad == 2'd1);
          beats_left_q <= n_pad - 2'd1;
          pad_mode_q   <= 1'b1;
          last_seen_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_padder.sv
// Bench for msg_padder: directed and randomized messages checked against a
// byte-level model of SHA-2 padding.
module tb_msg_padder;

  logic         axi_aclk = 1'b0;
  logic         axi_reset;
  logic [1:0]   sha_type;
  logic         en;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  int tests = 0;
  int fails = 0;

  logic [7:0]   msg_q [$];
  logic [511:0] exp_q [$];
  logic [511:0] got_q [$];

  msg_padder #(.S_AXIS_DATA_WIDTH(64), .M_AXIS_DATA_WIDTH(512)) dut (
    .axi_aclk     (axi_aclk),
    .axi_reset    (axi_reset),
    .sha_type     (sha_type),
    .en           (en),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Padded message per SHA-2 rules, cut into 64-byte beats.
  function automatic void build_exp(input logic [1:0] t);
    logic [7:0]   p [$];
    int           blk, fld;
    logic [63:0]  bits;
    logic [511:0] beat;
    blk  = t[1] ? 128 : 64;
    fld  = t[1] ? 16 : 8;
    bits = 64'(msg_q.size()) * 64'd8;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % blk) != (blk - fld)) p.push_back(8'h00);
    for (int i = fld - 1; i >= 0; i--) p.push_back(i < 8 ? 8'(bits >> (8 * i)) : 8'h00);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      beat = '0;
      for (int j = 0; j < 64; j++) beat[8*j +: 8] = p[64*b + j];
      exp_q.push_back(beat);
    end
  endfunction

  // Send msg_q as one message of type t and check every output beat and cycle.
  task automatic run_msg(input logic [1:0] t, input int stall_beat, input bit rnd);
    int   in_idx, out_idx, cyc, k, stall_cnt, exp_v, exp_p, len;
    bit   in_done, held_v, s_hs, m_hs;
    logic [511:0] held;
    len = msg_q.size();
    build_exp(t);
    got_q.delete();
    in_idx = 0; out_idx = 0; cyc = 0; stall_cnt = 0; exp_v = -1; exp_p = -1;
    in_done = 0; held_v = 0; held = '0;
    en = 1'b1; sha_type = t;
    @(posedge axi_aclk); @(negedge axi_aclk);
    chk("start_ready", 512'(s_axis_tready), 512'(1));
    en = rnd;
    sha_type = rnd ? 2'($urandom) : t;
    while (out_idx < exp_q.size() && cyc < 4000) begin
      k = ((len - in_idx) > 8) ? 8 : (len - in_idx);
      if (!in_done) begin
        s_axis_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_axis_tdata  = {$urandom, $urandom};
        for (int j = 0; j < k; j++) s_axis_tdata[8*j +: 8] = msg_q[in_idx + j];
        s_axis_tkeep  = 8'((9'h1 << k) - 9'h1);
        s_axis_tlast  = (in_idx + k == len);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '0;
      end
      if (m_axis_tvalid && out_idx == stall_beat && stall_cnt < 10) begin
        m_axis_tready = 1'b0;
        stall_cnt++;
      end else begin
        m_axis_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (m_axis_tvalid) chk("ready_excl", 512'(s_axis_tready), 512'(0));
      if (held_v) begin
        chk("hold_valid", 512'(m_axis_tvalid), 512'(1));
        chk("hold_data", m_axis_tdata, held);
      end
      if (cyc == exp_v) chk("valid_latency", 512'(m_axis_tvalid), 512'(1));
      if (cyc == exp_p) chk("pad_gap", 512'(m_axis_tvalid), 512'(0));
      s_hs = s_axis_tvalid && s_axis_tready;
      m_hs = m_axis_tvalid && m_axis_tready;
      if (m_hs) begin
        chk("beat_data", m_axis_tdata, exp_q[out_idx]);
        chk("beat_last", 512'(m_axis_tlast), 512'(out_idx == exp_q.size() - 1));
        got_q.push_back(m_axis_tdata);
        out_idx++;
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held   = m_axis_tdata;
      if (s_hs) begin
        in_idx += k;
        if (s_axis_tlast) begin
          in_done = 1'b1;
          en      = 1'b0;
        end
        if (k > 0 && (in_idx % 64) == 0) exp_v = cyc + 1;
        else if (s_axis_tlast) begin
          exp_p = cyc + 1;
          exp_v = cyc + 2;
        end
      end
      @(posedge axi_aclk); @(negedge axi_aclk);
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    en            = 1'b0;
    chk("beats_out", 512'(out_idx), 512'(exp_q.size()));
    chk("end_valid", 512'(m_axis_tvalid), 512'(0));
    chk("end_ready", 512'(s_axis_tready), 512'(0));
  endtask

  initial begin
    logic [511:0] b;
    axi_reset = 1'b1; sha_type = 2'b00; en = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_reset = 1'b0;
    @(posedge axi_aclk); @(negedge axi_aclk);
    chk("rst_s_ready", 512'(s_axis_tready), 512'(0));
    chk("rst_m_valid", 512'(m_axis_tvalid), 512'(0));
    chk("rst_m_last", 512'(m_axis_tlast), 512'(0));
    chk("rst_m_data", m_axis_tdata, 512'(0));

    // SHA256 "abc"
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(2'b01, -1, 1'b0);
    b = got_q[0];
    chk("abc_low", 512'(b[31:0]), 512'(32'h80636261));
    chk("abc_len", 512'(b[511:504]), 512'(8'h18));

    // SHA256 empty message
    msg_q.delete();
    run_msg(2'b01, -1, 1'b0);
    b = got_q[0];
    chk("empty_beat", b, 512'h80);

    // SHA256 56 bytes: length spills into an extra block
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'(i));
    run_msg(2'b01, -1, 1'b0);
    chk("b56_count", 512'(got_q.size()), 512'(2));
    b = got_q[0];
    chk("b56_term", 512'(b[455:448]), 512'(8'h80));
    b = got_q[1];
    chk("b56_len", b, {16'hC001, 496'h0});

    // SHA512 112 bytes, first output beat stalled for 10 cycles
    msg_q.delete();
    for (int i = 0; i < 112; i++) msg_q.push_back(8'(i + 7));
    run_msg(2'b11, 0, 1'b0);
    chk("b112_count", 512'(got_q.size()), 512'(4));
    b = got_q[1];
    chk("b112_term", 512'(b[391:384]), 512'(8'h80));
    b = got_q[3];
    chk("b112_len", 512'(b[511:496]), 512'(16'h8003));

    // Exact block fill with tlast on the filling beat
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
    run_msg(2'b00, -1, 1'b0);
    msg_q.delete();
    for (int i = 0; i < 128; i++) msg_q.push_back(8'($urandom));
    run_msg(2'b10, 1, 1'b0);

    // Randomized messages, types and flow control
    for (int n = 0; n < 14; n++) begin
      int len;
      len = $urandom_range(0, 300);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      run_msg(2'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset in the middle of a message
    en = 1'b1; sha_type = 2'b01;
    @(posedge axi_aclk); @(negedge axi_aclk);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      @(posedge axi_aclk); @(negedge axi_aclk);
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    axi_reset     = 1'b1;
    @(posedge axi_aclk); @(negedge axi_aclk);
    chk("midrst_s_ready", 512'(s_axis_tready), 512'(0));
    chk("midrst_m_valid", 512'(m_axis_tvalid), 512'(0));
    chk("midrst_m_last", 512'(m_axis_tlast), 512'(0));
    chk("midrst_m_data", m_axis_tdata, 512'(0));
    axi_reset     = 1'b0;
    s_axis_tvalid = 1'b1;
    @(posedge axi_aclk); @(negedge axi_aclk);
    chk("midrst_idle", 512'(s_axis_tready), 512'(0));
    chk("midrst_no_out", 512'(m_axis_tvalid), 512'(0));
    s_axis_tvalid = 1'b0;
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(2'b01, -1, 1'b0);
    b = got_q[0];
    chk("post_rst_abc", b, {8'h18, 472'h0, 32'h80636261});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
